router_ctrl: RTL and testbench
==============================

Name: router_ctrl

Overview:
- Control block for the 1x3 router.
- Sequences writing of one packet at a time into fifo_0/fifo_1/fifo_2 through a state machine: header decode, first-data load, payload load, parity load, full stall, wait-till-empty.
- Latches the destination address and generates the one-hot FIFO write enables and valid-out flags.
- Runs a per-FIFO idle timer that issues a soft reset to any output FIFO its reader leaves unread too long.

Parameters:
- SOFT_RST_TIMEOUT, 30: consecutive cycles with vld_out[i]=1 and read_enb[i]=0 before soft_rst[i] pulses.
- TMR_W, 5: width of each idle timer; must hold SOFT_RST_TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source is driving header/payload bytes; drops on the cycle the parity byte is presented
- addr_in  in  2  data_in[1:0] of the current byte; 2'b11 is an invalid destination
- parity_done  in  1  packet register has captured the parity byte
- low_pkt_valid  in  1  pkt_valid fell while the FSM was stalled in FIFO_FULL_STATE
- fifo_full  in  3  full flags of fifo_2..fifo_0
- fifo_empty  in  3  empty flags of fifo_2..fifo_0
- read_enb  in  3  reader-side read enables
- write_enb  out  3  one-hot FIFO write enable
- lfd_state  out  1  state==LOAD_FIRST_DATA, forwarded with the header byte to the FIFO
- detect_add  out  1  state==DECODE_ADDRESS
- ld_state  out  1  state==LOAD_DATA
- laf_state  out  1  state==LOAD_AFTER_FULL
- full_state  out  1  state==FIFO_FULL_STATE
- rst_int_reg  out  1  state==CHECK_PARITY_ERROR
- busy  out  1  source must hold its byte
- fifo_full_sel  out  1  fifo_full[addr_q]
- vld_out  out  3  vld_out[i] = ~fifo_empty[i], combinational
- soft_rst  out  3  one-cycle soft reset to fifo_i

Behaviour:
Reset (rstn=0):
- State goes to DECODE_ADDRESS, addr_q to 2'b00, all timers to 0, soft_rst to 3'b000.
- Decoded outputs follow the state: detect_add=1, busy=0, write_enb=000.

Address latch:
- addr_q <= addr_in when state==DECODE_ADDRESS, pkt_valid=1 and addr_in!=2'b11.
- Otherwise addr_q holds.
- write_enb = one-hot(addr_q) when state is one of LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; otherwise 000.

State transitions (registered, one per clock):
- DECODE_ADDRESS:
  - pkt_valid & addr_in!=11 & fifo_empty[addr_in] -> LOAD_FIRST_DATA
  - pkt_valid & addr_in!=11 & ~fifo_empty[addr_in] -> WAIT_TILL_EMPTY
  - addr_in==11 or ~pkt_valid -> stay (packet dropped, nothing written)
- WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA: -> LOAD_DATA unconditionally (header written this cycle).
- LOAD_DATA:
  - fifo_full_sel -> FIFO_FULL_STATE
  - else ~pkt_valid -> LOAD_PARITY
  - else stay
- FIFO_FULL_STATE: ~fifo_full_sel -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS
  - else low_pkt_valid -> LOAD_PARITY
  - else -> LOAD_DATA
- LOAD_PARITY: -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full_sel -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.

busy:
- busy=0 in DECODE_ADDRESS and LOAD_DATA; busy=1 in every other state.

Soft reset timer (per FIFO i):
- Clears when vld_out[i]=0 or read_enb[i]=1.
- Otherwise increments.
- When it reaches SOFT_RST_TIMEOUT-1 with the stall condition still true, soft_rst[i]=1 for exactly one cycle and the timer clears the same cycle.
- Stall intervals of SOFT_RST_TIMEOUT-1 cycles or fewer never pulse.

Abort on soft reset:
- If soft_rst[addr_q]=1 while the state is not DECODE_ADDRESS, the next state is DECODE_ADDRESS, overriding every transition above.

Simultaneous events:
- fifo_full_sel and ~pkt_valid together in LOAD_DATA: the full path wins.
- A FIFO that is not the current destination may time out and pulse soft_rst without affecting the FSM.

Reset mid-packet:
- rstn low in any state forces DECODE_ADDRESS immediately (asynchronous).
- write_enb drops in the same instant.

Test Plan:
- Reset then idle: rstn=0 for 2 cycles -> detect_add=1, busy=0, write_enb=000, soft_rst=000, state DECODE_ADDRESS.
- 14-byte packet to port 1, all FIFOs empty: header {6'd14,2'b01} with pkt_valid=1 -> LOAD_FIRST_DATA next cycle, lfd_state=1, write_enb=010. Then 14 cycles in LOAD_DATA with busy=0. pkt_valid=0 -> LOAD_PARITY (busy=1) -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE_ADDRESS. Exactly 16 cycles with write_enb=010.
- Destination busy: fifo_empty=3'b011, header addr 2'b10 -> WAIT_TILL_EMPTY, busy=1, write_enb=000. Set fifo_empty[2]=1 -> LOAD_FIRST_DATA next cycle, write_enb=100.
- Full stall: fifo_full[0]=1 during LOAD_DATA of a port-0 packet -> FIFO_FULL_STATE, busy=1, write_enb=000. Drop full with parity_done=0 and low_pkt_valid=0 -> LOAD_AFTER_FULL -> LOAD_DATA. Repeat with low_pkt_valid=1 -> LOAD_PARITY.
- Invalid address: header addr 2'b11 with pkt_valid=1 -> stays in DECODE_ADDRESS, write_enb=000 for the whole packet.
- Soft reset timeout: fifo_empty[2]=0, read_enb[2]=0 -> soft_rst[2] pulses exactly once, on the 30th stalled cycle, then again 30 cycles later. read_enb[2]=1 at cycle 29 -> no pulse. If addr_q=2 mid-packet when the pulse fires -> FSM in DECODE_ADDRESS next cycle.

Source files
------------

// File: rtl/router_ctrl.sv
// Write-side controller for the 1x3 router: sequences one packet at a time into
// the selected output FIFO and soft-resets any FIFO its reader leaves unread.
module router_ctrl #(
  parameter int SOFT_RST_TIMEOUT = 30,
  parameter int TMR_W            = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] addr_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       fifo_full_sel,
  output logic [2:0] vld_out,
  output logic [2:0] soft_rst
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [2:0] stall;

  // Padded to four entries so address 2'b11 indexes a harmless zero.
  logic [3:0] empty_ext, full_ext, soft_ext;
  assign empty_ext = {1'b0, fifo_empty};
  assign full_ext  = {1'b0, fifo_full};
  assign soft_ext  = {1'b0, soft_rst};

  assign vld_out       = ~fifo_empty;
  assign fifo_full_sel = full_ext[addr_q];

  // Idle timers: the pulse fires on the final stalled cycle and restarts the count.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_tmr
      logic [TMR_W-1:0] tmr_q;

      assign stall[gi]    = vld_out[gi] & ~read_enb[gi];
      assign soft_rst[gi] = stall[gi] && (tmr_q == TMR_W'(SOFT_RST_TIMEOUT - 1));

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          tmr_q <= '0;
        end else if (!stall[gi] || soft_rst[gi]) begin
          tmr_q <= '0;
        end else begin
          tmr_q <= tmr_q + TMR_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && addr_in != 2'b11) begin
          addr_d  = addr_in;
          state_d = empty_ext[addr_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_ext[addr_q]) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full_sel)   state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full_sel) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // A soft reset of the destination FIFO abandons the packet in progress.
    if (state_q != DECODE_ADDRESS && soft_ext[addr_q]) state_d = DECODE_ADDRESS;
  end

  assign detect_add  = (state_q == DECODE_ADDRESS);
  assign lfd_state   = (state_q == LOAD_FIRST_DATA);
  assign ld_state    = (state_q == LOAD_DATA);
  assign laf_state   = (state_q == LOAD_AFTER_FULL);
  assign full_state  = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg = (state_q == CHECK_PARITY_ERROR);
  assign busy        = !(state_q == DECODE_ADDRESS || state_q == LOAD_DATA);

  always_comb begin
    write_enb = 3'b000;
    if (state_q == LOAD_FIRST_DATA || state_q == LOAD_DATA ||
        state_q == LOAD_PARITY || state_q == LOAD_AFTER_FULL) begin
      write_enb = 3'b001 << addr_q;
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Randomized and directed bench for router_ctrl, checked every cycle against a
// behavioural packet/run-length model.
module tb_router_ctrl;
  localparam int TIMEOUT = 30;
  localparam int S_DA = 0, S_WTE = 1, S_LFD = 2, S_LD = 3, S_FULL = 4, S_LAF = 5,
                 S_LP = 6, S_CPE = 7;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] addr_in = 2'b00;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] read_enb = 3'b000;
  logic [2:0] write_enb, vld_out, soft_rst;
  logic       lfd_state, detect_add, ld_state, laf_state, full_state;
  logic       rst_int_reg, busy, fifo_full_sel;

  router_ctrl #(.SOFT_RST_TIMEOUT(TIMEOUT), .TMR_W(5)) dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .addr_in(addr_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .write_enb(write_enb), .lfd_state(lfd_state), .detect_add(detect_add),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy), .fifo_full_sel(fifo_full_sel),
    .vld_out(vld_out), .soft_rst(soft_rst)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: packet-level state, latched destination and per-FIFO stall run lengths.
  int         m_st = S_DA;
  logic [1:0] m_addr = 2'b00;
  int         run_len[3] = '{0, 0, 0};
  logic       rst_drive = 1'b1;

  logic [2:0] cap_we, cap_sr;
  logic       cap_detect, cap_busy, cap_lfd, cap_rst_int, cap_full, cap_ld, cap_laf;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_DA;
    m_addr = 2'b00;
    for (int i = 0; i < 3; i++) run_len[i] = 0;
  endtask

  task automatic step(input logic pv, input logic [1:0] ad, input logic pd,
                      input logic lpv, input logic [2:0] ff, input logic [2:0] fe,
                      input logic [2:0] re);
    int nst;
    logic [1:0] naddr;
    logic [2:0] stall, exp_sr, exp_we;
    @(negedge clk);
    rstn = rst_drive;
    pkt_valid = pv; addr_in = ad; parity_done = pd; low_pkt_valid = lpv;
    fifo_full = ff; fifo_empty = fe; read_enb = re;
    if (!rstn) model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      stall[i]  = !fe[i] && !re[i];
      exp_sr[i] = rstn && stall[i] && (((run_len[i] + 1) % TIMEOUT) == 0);
    end
    exp_we = (m_st == S_LFD || m_st == S_LD || m_st == S_LP || m_st == S_LAF)
             ? (3'b001 << m_addr) : 3'b000;
    chk("write_enb", write_enb, exp_we);
    chk("soft_rst", soft_rst, exp_sr);
    chk("vld_out", vld_out, ~fe);
    chk("busy", {2'b00, busy}, {2'b00, !(m_st == S_DA || m_st == S_LD)});
    chk("detect_add", {2'b00, detect_add}, {2'b00, m_st == S_DA});
    chk("lfd_state", {2'b00, lfd_state}, {2'b00, m_st == S_LFD});
    chk("ld_state", {2'b00, ld_state}, {2'b00, m_st == S_LD});
    chk("laf_state", {2'b00, laf_state}, {2'b00, m_st == S_LAF});
    chk("full_state", {2'b00, full_state}, {2'b00, m_st == S_FULL});
    chk("rst_int_reg", {2'b00, rst_int_reg}, {2'b00, m_st == S_CPE});
    chk("fifo_full_sel", {2'b00, fifo_full_sel}, {2'b00, ff[m_addr]});
    cap_we = write_enb; cap_sr = soft_rst; cap_detect = detect_add; cap_busy = busy;
    cap_lfd = lfd_state; cap_rst_int = rst_int_reg; cap_full = full_state;
    cap_ld = ld_state; cap_laf = laf_state;

    nst = m_st;
    naddr = m_addr;
    case (m_st)
      S_DA:   if (pv && ad != 2'b11) begin
                naddr = ad;
                nst = fe[ad] ? S_LFD : S_WTE;
              end
      S_WTE:  if (fe[m_addr]) nst = S_LFD;
      S_LFD:  nst = S_LD;
      S_LD:   nst = ff[m_addr] ? S_FULL : (!pv ? S_LP : S_LD);
      S_FULL: if (!ff[m_addr]) nst = S_LAF;
      S_LAF:  nst = pd ? S_DA : (lpv ? S_LP : S_LD);
      S_LP:   nst = S_CPE;
      S_CPE:  nst = ff[m_addr] ? S_FULL : S_DA;
      default: nst = S_DA;
    endcase
    if (m_st != S_DA && exp_sr[m_addr]) nst = S_DA;

    @(posedge clk);
    if (rstn) begin
      m_st = nst;
      m_addr = naddr;
      for (int i = 0; i < 3; i++) run_len[i] = stall[i] ? run_len[i] + 1 : 0;
    end
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, first, second;

    $display("[TB] reset then idle");
    rst_drive = 1'b0;
    idle();
    idle();
    chk("rst_detect", {2'b00, cap_detect}, 3'b001);
    chk("rst_busy", {2'b00, cap_busy}, 3'b000);
    chk("rst_we", cap_we, 3'b000);
    chk("rst_sr", cap_sr, 3'b000);
    rst_drive = 1'b1;
    idle();

    $display("[TB] 14-byte packet to port 1");
    cnt = 0;
    step(1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    chk("pkt14_lfd", {2'b00, cap_lfd}, 3'b001);
    chk("pkt14_lfd_we", cap_we, 3'b010);
    if (cap_we == 3'b010) cnt++;
    for (int i = 0; i < 14; i++) begin
      step(i != 13, 2'($urandom), 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
      if (cap_we == 3'b010) cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
      if (cap_we == 3'b010) cnt++;
      if (i == 1) chk("pkt14_rst_int", {2'b00, cap_rst_int}, 3'b001);
    end
    chk_int("pkt14_write_cycles", cnt, 16);

    $display("[TB] destination busy");
    step(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 3'b011, 3'b100);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b011, 3'b100);
    chk("wte_busy", {2'b00, cap_busy}, 3'b001);
    chk("wte_we", cap_we, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    chk("wte_lfd_we", cap_we, 3'b100);
    step(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    idle(); idle(); idle();

    $display("[TB] full stall on port 0");
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 3'b111, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 3'b111, 3'b000);
    chk("full_state_lit", {2'b00, cap_full}, 3'b001);
    chk("full_busy", {2'b00, cap_busy}, 3'b001);
    chk("full_we", cap_we, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    chk("laf_lit", {2'b00, cap_laf}, 3'b001);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 3'b111, 3'b000);
    chk("laf_to_ld", {2'b00, cap_ld}, 3'b001);
    step(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    step(1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 3'b111, 3'b000);
    step(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    chk("laf_to_lp_we", cap_we, 3'b001);
    chk("laf_to_lp_busy", {2'b00, cap_busy}, 3'b001);
    idle(); idle();

    $display("[TB] invalid address");
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b11, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
      if (cap_we != 3'b000 || !cap_detect) cnt++;
    end
    chk_int("invalid_addr_activity", cnt, 0);
    idle();

    $display("[TB] soft reset timeout on fifo 2");
    first = -1; second = -1; cnt = 0;
    for (int i = 1; i <= 65; i++) begin
      step(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b011, 3'b000);
      if (cap_sr[2]) begin
        cnt++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
    end
    chk_int("sr_pulses", cnt, 2);
    chk_int("sr_first", first, 30);
    chk_int("sr_second", second, 60);
    idle();
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b011, (i == 29) ? 3'b100 : 3'b000);
      if (cap_sr[2]) cnt++;
    end
    chk_int("sr_read_breaks_run", cnt, 0);
    idle();

    $display("[TB] soft reset aborts packet to port 2");
    step(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    for (int i = 1; i <= 30; i++)
      step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b011, 3'b000);
    chk("abort_pulse", cap_sr, 3'b100);
    step(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    chk("abort_detect", {2'b00, cap_detect}, 3'b001);
    idle();

    $display("[TB] asynchronous reset mid-packet");
    step(1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    rst_drive = 1'b0;
    step(1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 3'b111, 3'b000);
    chk("async_rst_we", cap_we, 3'b000);
    chk("async_rst_detect", {2'b00, cap_detect}, 3'b001);
    idle();
    rst_drive = 1'b1;
    idle();

    $display("[TB] randomized traffic");
    for (int seg = 0; seg < 60; seg++) begin
      logic [2:0] fe_seg, re_seg, fe, re, ff;
      int len;
      fe_seg = 3'($urandom) | 3'($urandom);
      re_seg = 3'($urandom) & 3'($urandom);
      len = $urandom_range(10, 60);
      for (int k = 0; k < len; k++) begin
        fe = fe_seg ^ ((($urandom % 10) == 0) ? 3'($urandom) : 3'b000);
        re = re_seg ^ ((($urandom % 10) == 0) ? 3'($urandom) : 3'b000);
        for (int b = 0; b < 3; b++) ff[b] = (($urandom % 8) == 0);
        step(($urandom % 4) != 0, 2'($urandom), ($urandom % 6) == 0,
             ($urandom % 6) == 0, ff, fe, re);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
